// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch slice.
package fetch_pkg;

    localparam int unsigned COMMON_WIDTH = 32;
    localparam logic [COMMON_WIDTH-1:0] INST_BYTES = 32'd4;
    localparam logic [COMMON_WIDTH-1:0] NOP_INST   = 32'h0000_0013;

    typedef struct packed {
        logic [COMMON_WIDTH-1:0] pc;
        logic [COMMON_WIDTH-1:0] inst;
    } fetch_entry_t;

    function automatic logic [COMMON_WIDTH-1:0] word_align(input logic [COMMON_WIDTH-1:0] addr);
        return {addr[COMMON_WIDTH-1:2], 2'b00};
    endfunction

endpackage

// File: rtl/fetch_queue.sv
// Synchronous FIFO of fetched {pc, inst} entries with single-cycle flush.
module fetch_queue
    import fetch_pkg::*;
#(
    parameter int unsigned QUEUE_DEPTH = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         push,
    input  fetch_entry_t push_data,
    input  logic         pop,
    input  logic         flush,
    output logic         full,
    output logic         empty,
    output fetch_entry_t head
);

    localparam int unsigned PTR_W = $clog2(QUEUE_DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;

    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    fetch_entry_t     mem_q [QUEUE_DEPTH];
    fetch_entry_t     mem_d [QUEUE_DEPTH];

    logic do_push;
    logic do_pop;

    assign full    = (count_q == CNT_W'(QUEUE_DEPTH));
    assign empty   = (count_q == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign head    = mem_q[rd_ptr_q];

    always_comb begin
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        count_d  = count_q;
        for (int unsigned i = 0; i < QUEUE_DEPTH; i++) begin
            mem_d[i] = mem_q[i];
        end

        if (!rst) begin
            rd_ptr_d = '0;
            wr_ptr_d = '0;
            count_d  = '0;
            for (int unsigned i = 0; i < QUEUE_DEPTH; i++) begin
                mem_d[i] = '0;
            end
        end else if (flush) begin
            // Flush drops pointers only; storage keeps stale data.
            rd_ptr_d = '0;
            wr_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (do_push) begin
                mem_d[wr_ptr_q] = push_data;
                wr_ptr_d        = wr_ptr_q + 1'b1;
            end
            if (do_pop) begin
                rd_ptr_d = rd_ptr_q + 1'b1;
            end
            case ({do_push, do_pop})
                2'b10:   count_d = count_q + 1'b1;
                2'b01:   count_d = count_q - 1'b1;
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        rd_ptr_q <= rd_ptr_d;
        wr_ptr_q <= wr_ptr_d;
        count_q  <= count_d;
        for (int unsigned i = 0; i < QUEUE_DEPTH; i++) begin
            mem_q[i] <= mem_d[i];
        end
    end

endmodule

// File: rtl/inst_fetch.sv
// Fetch stage: owns the PC, drives the ROM, queues fetched words toward decode.
module inst_fetch
    import fetch_pkg::*;
#(
    parameter logic [COMMON_WIDTH-1:0] RESET_PC    = 32'h0000_0000,
    parameter int unsigned             QUEUE_DEPTH = 4
) (
    input  logic                    clk,
    input  logic                    rst,
    output logic                    rom_ce,
    output logic [COMMON_WIDTH-1:0] rom_addr,
    input  logic [COMMON_WIDTH-1:0] rom_inst,
    input  logic                    redirect_valid,
    input  logic [COMMON_WIDTH-1:0] redirect_pc,
    output logic                    id_valid,
    input  logic                    id_ready,
    output logic [COMMON_WIDTH-1:0] id_inst,
    output logic [COMMON_WIDTH-1:0] id_pc
);

    logic [COMMON_WIDTH-1:0] pc_q, pc_d;

    logic         fetch;
    logic         q_full;
    logic         q_empty;
    fetch_entry_t q_head;
    fetch_entry_t q_push_data;

    // Fetch depends only on queue occupancy, never on id_ready.
    assign fetch       = rst && !q_full && !redirect_valid;
    assign rom_ce      = fetch;
    assign rom_addr    = pc_q;
    assign q_push_data = '{pc: pc_q, inst: rom_inst};

    assign id_valid = !q_empty;
    assign id_inst  = q_head.inst;
    assign id_pc    = q_head.pc;

    always_comb begin
        pc_d = pc_q;
        if (!rst) begin
            pc_d = RESET_PC;
        end else if (redirect_valid) begin
            pc_d = word_align(redirect_pc);
        end else if (fetch) begin
            pc_d = pc_q + INST_BYTES;
        end
    end

    always_ff @(posedge clk) begin
        pc_q <= pc_d;
    end

    fetch_queue #(
        .QUEUE_DEPTH (QUEUE_DEPTH)
    ) u_queue (
        .clk       (clk),
        .rst       (rst),
        .push      (fetch),
        .push_data (q_push_data),
        .pop       (id_valid && id_ready),
        .flush     (redirect_valid),
        .full      (q_full),
        .empty     (q_empty),
        .head      (q_head)
    );

endmodule
